// File: rtl/idct8_stream.sv
// ---------------------------------------------------------------------------
// idct8_stream
//   Streaming 8-point 1-D inverse DCT. One block of eight coefficients is
//   accepted through a valid/ready handshake, eight accumulators are updated
//   serially (one coefficient per cycle), and the rounded, clamped results
//   are presented through a second valid/ready handshake. It serves either
//   the row pass (signed, saturated output) or the column pass (unsigned
//   0..255 pixel output) of a 2-D IDCT.
//
//   Timing: accept on edge A, eight MAC cycles, out_valid high after edge
//   A+8. With out_ready held high the result transfers on edge A+9, the
//   block returns to IDLE and the next block can be accepted on edge A+10,
//   i.e. one block per 10 cycles.
//
// Parameters
//   IN_W      signed input coefficient width
//   COEF_W    signed cosine constant width (constants scaled by 256)
//   ACC_W     accumulator width
//   PIXEL_OUT 1: clamp to unsigned 0..255, 0: saturate to signed OUT_W
//   OUT_W     output sample width (8 when PIXEL_OUT=1)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, aborts any block in flight
//   in_valid   data_in holds a valid block
//   in_ready   block can be accepted (IDLE only)
//   data_in    x_0 in the MSBs ... x_7 in the LSBs, two's complement
//   out_valid  data_out holds a valid result
//   out_ready  downstream accepts the result
//   data_out   y_0 in the MSBs ... y_7 in the LSBs
//   busy       a block is being processed or held for output
//
// Build option
//   IDCT_LEVEL_SHIFT_EN: when defined and PIXEL_OUT=1, 128 is added to the
//   rounded value before the 0..255 clamp (JPEG level shift). Without it
//   negative values clamp to 0. Ignored when PIXEL_OUT=0.
// ---------------------------------------------------------------------------
module idct8_stream #(
    parameter int IN_W      = 11,
    parameter int COEF_W    = 9,
    parameter int ACC_W     = IN_W + COEF_W + 3,
    parameter int PIXEL_OUT = 1,
    parameter int OUT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   data_out,
    output logic                 busy
);

    localparam int PROD_W = IN_W + COEF_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             k_q, k_d;
    logic [8*IN_W-1:0]      x_q, x_d;
    logic signed [IN_W-1:0] x_cur;
    logic                   accept;
    logic                   mac_step;
    logic                   mac_last;

    // Cosine weight C(k,n) = 256*cos((2n+1)*k*pi/16), quantised to the
    // constant set c1..c7. The angle index m = (2n+1)*k is taken mod 32 and
    // folded into the first quadrant to pick the magnitude c_j and its sign.
    // k=0 uses c4 for every output (the 1/sqrt(2) DC weight).
    function automatic logic signed [COEF_W-1:0] cos_coef(
        input logic [2:0] k,
        input logic [4:0] odd_n
    );
        logic [4:0]               m;
        logic [3:0]               j;
        logic                     neg;
        logic [7:0]               mag;
        logic signed [COEF_W-1:0] v;
        m   = odd_n * {2'b00, k};
        j   = 4'd0;
        neg = 1'b0;
        case (m[4:3])
            2'd0: begin j = {1'b0, m[2:0]};        neg = 1'b0; end
            2'd1: begin j = 4'(5'd16 - m);         neg = 1'b1; end
            2'd2: begin j = {1'b0, m[2:0]};        neg = 1'b1; end
            default: begin j = 4'(6'd32 - {1'b0, m}); neg = 1'b0; end
        endcase
        if (k == 3'd0) begin
            j   = 4'd4;
            neg = 1'b0;
        end
        case (j)
            4'd1:    mag = 8'd251;
            4'd2:    mag = 8'd236;
            4'd3:    mag = 8'd213;
            4'd4:    mag = 8'd181;
            4'd5:    mag = 8'd142;
            4'd6:    mag = 8'd98;
            4'd7:    mag = 8'd50;
            default: mag = 8'd0;
        endcase
        v = COEF_W'(mag);
        if (neg) begin
            v = -v;
        end
        return v;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)       state_d = ST_MAC;
            ST_MAC:  if (k_q == 3'd7)    state_d = ST_OUT;
            ST_OUT:  if (out_ready)      state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_OUT);
        busy      = (state_q != ST_IDLE);
    end

    assign accept   = in_valid && (state_q == ST_IDLE);
    assign mac_step = (state_q == ST_MAC);
    assign mac_last = mac_step && (k_q == 3'd7);

    // ---------------- coefficient index and input latch ----------------
    always_comb begin
        k_d = k_q;
        x_d = x_q;
        if (accept) begin
            k_d = 3'd0;
            x_d = data_in;
        end else if (mac_step) begin
            k_d = k_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= 3'd0;
            x_q <= '0;
        end else begin
            k_q <= k_d;
            x_q <= x_d;
        end
    end

    // x_k for the current MAC cycle; x_0 sits in the MSBs.
    always_comb begin
        x_cur = '0;
        for (int i = 0; i < 8; i++) begin
            if (k_q == 3'(i)) begin
                x_cur = x_q[(7-i)*IN_W +: IN_W];
            end
        end
    end

    // ---------------- eight accumulator lanes ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            localparam logic [4:0] ODD = 5'(2*gi + 1);

            logic signed [COEF_W-1:0] coef;
            logic signed [PROD_W-1:0] prod;
            logic signed [ACC_W-1:0]  acc_q, acc_d;
            logic signed [ACC_W-1:0]  acc_sum;
            logic signed [ACC_W-1:0]  shr;
            logic signed [ACC_W-1:0]  rnd;
            logic [OUT_W-1:0]         y_sat;
            logic [OUT_W-1:0]         y_q, y_d;

            assign coef    = cos_coef(k_q, ODD);
            assign prod    = PROD_W'(coef) * PROD_W'(x_cur);
            assign acc_sum = acc_q + ACC_W'(prod);

            // Round half up of acc/512 at full width: floor(acc/512) plus
            // the first discarded bit.
            assign shr = acc_sum >>> 9;
            assign rnd = shr + ACC_W'(acc_sum[8]);

            if (PIXEL_OUT != 0) begin : g_pix
                localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);
                logic signed [ACC_W-1:0] lv;
                always_comb begin
`ifdef IDCT_LEVEL_SHIFT_EN
                    lv = rnd + ACC_W'(128);
`else
                    lv = rnd;
`endif
                    if (lv[ACC_W-1]) begin
                        y_sat = '0;
                    end else if (lv > PIX_MAX) begin
                        y_sat = OUT_W'(255);
                    end else begin
                        y_sat = lv[OUT_W-1:0];
                    end
                end
            end else begin : g_row
                localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (OUT_W-1)) - 1);
                localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
                always_comb begin
                    if (rnd > SAT_HI) begin
                        y_sat = SAT_HI[OUT_W-1:0];
                    end else if (rnd < SAT_LO) begin
                        y_sat = SAT_LO[OUT_W-1:0];
                    end else begin
                        y_sat = rnd[OUT_W-1:0];
                    end
                end
            end

            // Outputs only change on the final MAC cycle, so data_out is
            // stable for the whole OUT state regardless of back-pressure.
            always_comb begin
                acc_d = acc_q;
                y_d   = y_q;
                if (accept) begin
                    acc_d = '0;
                end else if (mac_step) begin
                    acc_d = acc_sum;
                    if (mac_last) begin
                        y_d = y_sat;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q <= '0;
                    y_q   <= '0;
                end else begin
                    acc_q <= acc_d;
                    y_q   <= y_d;
                end
            end

            assign data_out[(7-gi)*OUT_W +: OUT_W] = y_q;
        end
    endgenerate

endmodule
